i2c_target_unit: RTL

- I2C target (slave) that answers an external I2C controller on the same two-wire bus our controller blocks drive.
- Exposes a small byte-addressed register window to internal logic: write pointer, write data, read data, with auto-increment.
- Sits under a future I2C target block's CSR wrapper.
- No clock stretching; 7-bit addressing only.

---
 rtl/i2c_target_unit_if.sv | 22 ++
 rtl/i2c_target_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_unit_if.sv
// Register-window interface of the I2C target.
//   oRegAdrs  register pointer presented to internal logic
//   oRegWd    byte received from the bus
//   oRegWe    one-cycle write strobe (oRegAdrs/oRegWd valid with it)
//   oRegRe    one-cycle read strobe (iRegRd sampled the cycle after)
//   iRegRd    read data for oRegAdrs
//   oBusy     an address-matched transfer is in progress
// Modport slave is the I2C target side; master is the CSR/register side.
`timescale 1ns/1ps
interface i2c_target_unit_if #(
   parameter int unsigned pRegAdrsWidth = 8
);
   logic [pRegAdrsWidth-1:0] oRegAdrs;
   logic [7:0]               oRegWd;
   logic                     oRegWe;
   logic                     oRegRe;
   logic [7:0]               iRegRd;
   logic                     oBusy;

   modport slave  (output oRegAdrs, oRegWd, oRegWe, oRegRe, oBusy, input iRegRd);
   modport master (input oRegAdrs, oRegWd, oRegWe, oRegRe, oBusy, output iRegRd);
endinterface

// File: rtl/i2c_target_unit.sv
// I2C target (7-bit address, no clock stretching) exposing a byte-addressed
// register window with an auto-incrementing pointer.
//   iSCLK      system clock
//   iSRST      synchronous active-high reset
//   iI2CScl    bus SCL (asynchronous)
//   ioI2CSda   bus SDA, open drain (driven 0 or released)
//   io_reg_if  register window (pointer, write data/strobe, read strobe/data, busy)
`timescale 1ns/1ps
module i2c_target_unit #(
   parameter logic [6:0]  pSlaveAdrs    = 7'h20,
   parameter int unsigned pRegAdrsWidth = 8,
   parameter int unsigned pFilterLen    = 3
) (
   input  logic                   iSCLK,
   input  logic                   iSRST,
   input  logic                   iI2CScl,
   inout  wire                    ioI2CSda,
   i2c_target_unit_if.slave       io_reg_if
);

   localparam int unsigned CW = $clog2(pFilterLen + 1);

   typedef enum logic [3:0] {
      IDLE, ADRS, ADRS_ACK, WPTR, WPTR_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   // input conditioning
   logic [1:0]    r_scl_sync, r_sda_sync;
   logic [CW-1:0] r_scl_cnt, r_sda_cnt;
   logic          r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
   logic [CW-1:0] w_scl_cnt_nx, w_sda_cnt_nx;

   // protocol state
   state_t                   r_state;
   logic [7:0]               r_shift;
   logic [2:0]               r_bitcnt;
   logic                     r_ack_on;
   logic                     r_rw;
   logic                     r_nack;
   logic                     r_sda_oe;
   logic [pRegAdrsWidth-1:0] r_ptr;
   logic [7:0]               r_reg_wd;
   logic                     r_reg_we;
   logic                     r_reg_re;
   logic                     r_re_d;
   logic                     r_busy;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;

   assign ioI2CSda = r_sda_oe ? 1'b0 : 1'bz;

   assign io_reg_if.oRegAdrs = r_ptr;
   assign io_reg_if.oRegWd   = r_reg_wd;
   assign io_reg_if.oRegWe   = r_reg_we;
   assign io_reg_if.oRegRe   = r_reg_re;
   assign io_reg_if.oBusy    = r_busy;

   assign w_scl_cnt_nx = r_scl_cnt + CW'(1);
   assign w_sda_cnt_nx = r_sda_cnt + CW'(1);

   // Synchronizer plus run-length filter: the filtered level only follows the
   // synchronized pin after pFilterLen consecutive differing samples.
   always_ff @(posedge iSCLK) begin
      if (iSRST) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_cnt  <= '0;
         r_sda_cnt  <= '0;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_fd   <= 1'b1;
         r_sda_fd   <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], iI2CScl};
         r_sda_sync <= {r_sda_sync[0], ioI2CSda};
         r_scl_fd   <= r_scl_f;
         r_sda_fd   <= r_sda_f;
         if (r_scl_sync[1] == r_scl_f) begin
            r_scl_cnt <= '0;
         end else if (w_scl_cnt_nx == CW'(pFilterLen)) begin
            r_scl_f   <= r_scl_sync[1];
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= w_scl_cnt_nx;
         end
         if (r_sda_sync[1] == r_sda_f) begin
            r_sda_cnt <= '0;
         end else if (w_sda_cnt_nx == CW'(pFilterLen)) begin
            r_sda_f   <= r_sda_sync[1];
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= w_sda_cnt_nx;
         end
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_fd;
   assign w_scl_fall = ~r_scl_f & r_scl_fd;
   assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
   assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
   assign w_byte     = {r_shift[6:0], r_sda_f};

   always_ff @(posedge iSCLK) begin
      if (iSRST) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_bitcnt <= 3'd7;
         r_ack_on <= 1'b0;
         r_rw     <= 1'b0;
         r_nack   <= 1'b0;
         r_sda_oe <= 1'b0;
         r_ptr    <= '0;
         r_reg_wd <= '0;
         r_reg_we <= 1'b0;
         r_reg_re <= 1'b0;
         r_re_d   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_reg_we <= 1'b0;
         r_reg_re <= 1'b0;
         r_re_d   <= r_reg_re;
         // bus conditions outrank any SCL edge seen in the same cycle
         if (w_stop) begin
            r_state  <= IDLE;
            r_sda_oe <= 1'b0;
            r_ack_on <= 1'b0;
            r_busy   <= 1'b0;
         end else if (w_start) begin
            r_state  <= ADRS;
            r_sda_oe <= 1'b0;
            r_ack_on <= 1'b0;
            r_bitcnt <= 3'd7;
         end else begin
            case (r_state)
               IDLE, IGNORE: ;
               ADRS: if (w_scl_rise) begin
                  r_shift <= w_byte;
                  if (r_bitcnt == 3'd0) begin
                     r_rw <= r_sda_f;
                     if (r_shift[6:0] == pSlaveAdrs) begin
                        r_state <= ADRS_ACK;
                        r_busy  <= 1'b1;
                     end else begin
                        r_state <= IGNORE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_bitcnt <= r_bitcnt - 3'd1;
                  end
               end
               WPTR: if (w_scl_rise) begin
                  r_shift <= w_byte;
                  if (r_bitcnt == 3'd0) begin
                     r_ptr   <= pRegAdrsWidth'(w_byte);
                     r_state <= WPTR_ACK;
                  end else begin
                     r_bitcnt <= r_bitcnt - 3'd1;
                  end
               end
               WDATA: if (w_scl_rise) begin
                  r_shift <= w_byte;
                  if (r_bitcnt == 3'd0) begin
                     r_reg_wd <= w_byte;
                     r_reg_we <= 1'b1;
                     r_state  <= WDATA_ACK;
                  end else begin
                     r_bitcnt <= r_bitcnt - 3'd1;
                  end
               end
               // Entered on the 8th rising edge: the first falling edge starts
               // driving ACK, the second (end of the 9th clock) releases it.
               ADRS_ACK, WPTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     r_ack_on <= 1'b1;
                     r_sda_oe <= 1'b1;
                  end else begin
                     r_ack_on <= 1'b0;
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= 3'd7;
                     if (r_state == ADRS_ACK) begin
                        if (r_rw) begin
                           r_state  <= RDATA;
                           r_reg_re <= 1'b1;
                        end else begin
                           r_state <= WPTR;
                        end
                     end else if (r_state == WPTR_ACK) begin
                        r_state <= WDATA;
                     end else begin
                        r_ptr   <= r_ptr + pRegAdrsWidth'(1);
                        r_state <= WDATA;
                     end
                  end
               end
               // Shifter is loaded two cycles after the read strobe, i.e. the
               // cycle after iRegRd has been updated for the new pointer.
               RDATA: begin
                  if (r_re_d) begin
                     r_shift  <= io_reg_if.iRegRd;
                     r_sda_oe <= ~io_reg_if.iRegRd[7];
                  end else if (w_scl_fall) begin
                     if (r_bitcnt == 3'd0) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= RDATA_ACK;
                     end else begin
                        r_bitcnt <= r_bitcnt - 3'd1;
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_sda_oe <= ~r_shift[6];
                     end
                  end
               end
               RDATA_ACK: begin
                  if (w_scl_rise) begin
                     r_nack <= r_sda_f;
                  end else if (w_scl_fall) begin
                     r_ptr <= r_ptr + pRegAdrsWidth'(1);
                     if (r_nack) begin
                        r_state <= IGNORE;
                     end else begin
                        r_reg_re <= 1'b1;
                        r_bitcnt <= 3'd7;
                        r_state  <= RDATA;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
